// File: rtl/seg7_pkg.sv
// Segment pattern constants shared with the hex-to-seven-segment encoder,
// plus the readback decoder state type. Patterns are active low, bit 0 = a.
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      PRESENT
   } state_e;

endpackage

// File: rtl/seg7_digit_lookup.sv
// Combinational single-digit decoder: active-low 7-segment pattern to nibble,
// with blank (all segments off) and invalid (not a hex glyph) flags.
module seg7_digit_lookup
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] nib_o,
   output logic       invalid_o,
   output logic       blank_o
);

   always_comb begin
      nib_o     = 4'h0;
      invalid_o = 1'b0;
      blank_o   = 1'b0;
      case (seg_i)
         SEG_0:     nib_o = 4'h0;
         SEG_1:     nib_o = 4'h1;
         SEG_2:     nib_o = 4'h2;
         SEG_3:     nib_o = 4'h3;
         SEG_4:     nib_o = 4'h4;
         SEG_5:     nib_o = 4'h5;
         SEG_6:     nib_o = 4'h6;
         SEG_7:     nib_o = 4'h7;
         SEG_8:     nib_o = 4'h8;
         SEG_9:     nib_o = 4'h9;
         SEG_A:     nib_o = 4'hA;
         SEG_B:     nib_o = 4'hB;
         SEG_C:     nib_o = 4'hC;
         SEG_D:     nib_o = 4'hD;
         SEG_E:     nib_o = 4'hE;
         SEG_F:     nib_o = 4'hF;
         SEG_BLANK: blank_o = 1'b1;
         default:   invalid_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_readback_decoder.sv
// Watches a bank of seven-segment drives, waits for the whole set to settle,
// then decodes one digit per cycle and presents the result on valid/ready.
module seg7_readback_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 6,
   parameter int STABLE_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_DIGITS*7-1:0] seg_in,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [NUM_DIGITS*4-1:0] out_value,
   output logic [NUM_DIGITS-1:0]   out_invalid,
   output logic [NUM_DIGITS-1:0]   out_blank,
   output logic                    busy
);

   localparam int             IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [7:0]     STABLE_C = 8'(STABLE_CYCLES);

   logic [NUM_DIGITS-1:0][6:0] seg_q, snap_q, last_q;
   logic [NUM_DIGITS-1:0][3:0] val_q;
   logic [NUM_DIGITS-1:0]      inv_q, blk_q;
   logic [7:0]                 cnt_q, cnt_d;
   logic [IDX_W-1:0]           idx_q;
   logic                       first_q, valid_q, busy_q;
   state_e                     state_q;

   logic [3:0] lk_nib;
   logic       lk_inv, lk_blk;

   // Counter compares the incoming sample against the one being replaced,
   // so it stays aligned with seg_q.
   always_comb begin
      cnt_d = cnt_q;
      if (seg_in != seg_q)
         cnt_d = 8'd0;
      else if (cnt_q != STABLE_C)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_q <= {NUM_DIGITS{SEG_BLANK}};
         cnt_q <= 8'd0;
      end else begin
         seg_q <= seg_in;
         cnt_q <= cnt_d;
      end
   end

   seg7_digit_lookup u_lookup (
      .seg_i     (snap_q[idx_q]),
      .nib_o     (lk_nib),
      .invalid_o (lk_inv),
      .blank_o   (lk_blk)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         snap_q  <= '0;
         last_q  <= '1;
         first_q <= 1'b1;
         idx_q   <= '0;
         val_q   <= '0;
         inv_q   <= '0;
         blk_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // A settled pattern identical to the last report is suppressed.
               if (cnt_q == STABLE_C && (seg_q != last_q || first_q)) begin
                  snap_q  <= seg_q;
                  idx_q   <= '0;
                  first_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               val_q[idx_q] <= lk_nib;
               inv_q[idx_q] <= lk_inv;
               blk_q[idx_q] <= lk_blk;
               idx_q        <= idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  last_q  <= snap_q;
                  valid_q <= 1'b1;
                  state_q <= PRESENT;
               end
            end
            PRESENT: begin
               if (out_ready) begin
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_valid   = valid_q;
   assign out_value   = val_q;
   assign out_invalid = inv_q;
   assign out_blank   = blk_q;
   assign busy        = busy_q;

endmodule
